// File: rtl/alu_div16_seq.sv
// alu_div16_seq: iterative restoring divider, one quotient bit per clock.
// Quotient/remainder are held in registers between operations so the ALU
// result select can pick them at any time.
// Optional build macro DIV_SIGNED_EN: two's-complement operands, with the
// magnitudes divided by the same unsigned core and signs fixed up on write.
module alu_div16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder, always < divisor
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmo_q, rmo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // One iteration: the shifted remainder is WIDTH+1 bits; when it is >= the
  // divisor the difference is < divisor, so a WIDTH-bit subtract is exact.
  logic [WIDTH:0]   rem_sh;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
  assign qbit     = (rem_sh >= {1'b0, dvs_q});
  assign rem_next = qbit ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
  assign quo_next = {dvd_q[WIDTH-2:0], qbit};

  logic [WIDTH-1:0] a_in, b_in;     // operands as fed to the unsigned core
  logic [WIDTH-1:0] quo_fin, rmo_fin;

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  assign a_in    = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_in    = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign quo_fin = qneg_q ? (~quo_next + 1'b1) : quo_next;
  assign rmo_fin = rneg_q ? (~rem_next + 1'b1) : rem_next;

  // Signs captured at accept; applied in the result-write cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign a_in    = dividend;
  assign b_in    = divisor;
  assign quo_fin = quo_next;
  assign rmo_fin = rem_next;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmo_d   = rmo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dz_d   = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rmo_d   = dividend;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            dvd_d   = a_in;
            dvs_d   = b_in;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_CALC;
`ifdef DIV_SIGNED_EN
            qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d  = dividend[WIDTH-1];
`endif
          end
        end
      end
      S_CALC: begin
        rem_d = rem_next;
        dvd_d = quo_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quo_d   = quo_fin;
          rmo_d   = rmo_fin;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmo_q   <= rmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_alu_div16_seq.sv
// Directed bench for alu_div16_seq: latency, results, back-to-back issue,
// divide-by-zero, held start, mid-operation reset, signed cases when built
// with DIV_SIGNED_EN.
module tb_alu_div16_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int t0 = 0;
  int s0, n0, lat;

  alu_div16_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands on a falling edge, start accepted at the next rising edge
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1 t0 = cyc;
    start = 1'b0;
  endtask

  // Cycles from the accept edge to the cycle where done is seen; -1 if none
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        l = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q", quotient, 0);  chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    rst_n = 1'b1;

    // 100/7
    issue(16'd100, 16'd7);
    @(negedge clk); chk("busy_rise", busy, 1);
    wait_done(lat);
    chk("lat_100_7", lat, 16); chk("q_100_7", quotient, 14);
    chk("r_100_7", remainder, 2); chk("dz_100_7", div_by_zero, 0);
    @(negedge clk); chk("busy_fall", busy, 0); chk("done_pulse", done, 0);

    // back-to-back at the earliest issue
    issue(16'hFFFF, 16'd1);
    n0 = done_cnt; s0 = t0;
    wait_done(lat);
    chk("q_ffff_1", quotient, 16'hFFFF); chk("r_ffff_1", remainder, 0);
    issue(16'd5, 16'd9);
    chk("issue_interval", t0 - s0, 18);
    wait_done(lat);
    chk("lat_5_9", lat, 16); chk("q_5_9", quotient, 0); chk("r_5_9", remainder, 5);
    @(negedge clk);
    chk("b2b_done_count", done_cnt - n0, 2);

    // divide by zero, then a normal op clears the flag
    issue(16'd1234, 16'd0);
    wait_done(lat);
    chk("lat_dz", lat, 0); chk("q_dz", quotient, 16'hFFFF);
    chk("r_dz", remainder, 1234); chk("dz_set", div_by_zero, 1);
    s0 = t0;
    issue(16'd10, 16'd3);
    chk("dz_interval", t0 - s0, 2);
    @(negedge clk);
    chk("dz_clear", div_by_zero, 0); chk("q_hold", quotient, 16'hFFFF);
    wait_done(lat);
    chk("lat_10_3", lat, 16); chk("q_10_3", quotient, 3); chk("r_10_3", remainder, 1);

    // start held high, operands toggling during CALC
    @(negedge clk);
    start = 1'b1; dividend = 16'd200; divisor = 16'd7;
    @(posedge clk);
    #1 t0 = cyc; s0 = t0; n0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dividend = 16'($urandom); divisor = 16'($urandom_range(0, 3));
    end
    @(negedge clk);
    dividend = 16'd90; divisor = 16'd4;
    wait_done(lat);
    chk("lat_hold_a", lat, 16); chk("q_200_7", quotient, 28); chk("r_200_7", remainder, 4);
    t0 = s0 + 18;
    wait_done(lat);
    chk("lat_hold_b", lat, 16); chk("q_90_4", quotient, 22); chk("r_90_4", remainder, 2);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_done_count", done_cnt - n0, 2);

    // reset at E8 of 50000/3
    issue(16'd50000, 16'd3);
    n0 = done_cnt;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_q", quotient, 0); chk("abort_r", remainder, 0);
    chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_dz", div_by_zero, 0);
    rst_n = 1'b1;
    wait_done(lat);
    chk("abort_no_done", lat, -1); chk("abort_done_count", done_cnt - n0, 0);
    issue(16'd9, 16'd3);
    wait_done(lat);
    chk("q_9_3", quotient, 3); chk("r_9_3", remainder, 0);

    issue(16'hFFFF, 16'hFFFF);
    wait_done(lat);
    chk("q_ffff_ffff", quotient, 1); chk("r_ffff_ffff", remainder, 0);

`ifdef DIV_SIGNED_EN
    issue(16'hFFF9, 16'd2);
    wait_done(lat);
    chk("lat_s", lat, 16); chk("q_m7_2", quotient, 16'hFFFD); chk("r_m7_2", remainder, 16'hFFFF);
    issue(16'd7, 16'hFFFE);
    wait_done(lat);
    chk("q_7_m2", quotient, 16'hFFFD); chk("r_7_m2", remainder, 1);
    issue(16'h8000, 16'hFFFF);
    wait_done(lat);
    chk("q_min_m1", quotient, 16'h8000); chk("r_min_m1", remainder, 0);
`else
    issue(16'h8000, 16'hFFFF);
    wait_done(lat);
    chk("q_8000_ffff", quotient, 0); chk("r_8000_ffff", remainder, 16'h8000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
